// File: rtl/virtual_pin_pkg.sv
// Shared constants, address map and helpers for the virtual-pin bridge.
// Imported by the bus interface, the bridge top and its pulse timer.
package virtual_pin_pkg;

  localparam int unsigned AVS_ADDR_W = 5;
  localparam int unsigned AVS_DATA_W = 32;
  localparam int unsigned LEDR_W     = 10;
  localparam int unsigned HEX_W      = 8;

  localparam logic [AVS_ADDR_W-1:0] ADDR_ID         = 5'h00;
  localparam logic [AVS_ADDR_W-1:0] ADDR_IN_LO      = 5'h01;
  localparam logic [AVS_ADDR_W-1:0] ADDR_IN_HI      = 5'h02;
  localparam logic [AVS_ADDR_W-1:0] ADDR_SW_KEY     = 5'h03;
  localparam logic [AVS_ADDR_W-1:0] ADDR_KEY_PULSE  = 5'h04;
  localparam logic [AVS_ADDR_W-1:0] ADDR_STATUS     = 5'h05;
  localparam logic [AVS_ADDR_W-1:0] ADDR_CTRL       = 5'h06;
  localparam logic [AVS_ADDR_W-1:0] ADDR_PARAM_BASE = 5'h10;

  localparam logic [AVS_DATA_W-1:0] ID_VALUE = 32'h5650_0002;

  localparam int unsigned STAT_CHG  = 0;
  localparam int unsigned STAT_PEND = 1;
  localparam int unsigned STAT_HOLD = 2;

  // Snapshot of the user design's visible outputs, MSB first.
  typedef struct packed {
    logic [HEX_W-1:0]  hex5;
    logic [HEX_W-1:0]  hex4;
    logic [HEX_W-1:0]  hex3;
    logic [HEX_W-1:0]  hex2;
    logic [HEX_W-1:0]  hex1;
    logic [HEX_W-1:0]  hex0;
    logic [LEDR_W-1:0] ledr;
  } user_pins_t;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = 32'(i + 1);
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/virtual_pin_bridge_if.sv
// Avalon-MM style host port of the virtual-pin bridge.
// The host side is the master; the bridge is the slave.
interface virtual_pin_bridge_if;
  import virtual_pin_pkg::*;

  logic [AVS_ADDR_W-1:0] avs_address;
  logic                  avs_write;
  logic [AVS_DATA_W-1:0] avs_writedata;
  logic                  avs_read;
  logic [AVS_DATA_W-1:0] avs_readdata;
  logic                  avs_readdatavalid;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/vpb_pulse_timer.sv
// Self-timed KEY pulses: one shared down-counter and a mask of active keys.
// Any non-zero trigger adds its keys and restarts the window for all of them.
module vpb_pulse_timer
  import virtual_pin_pkg::*;
#(
  parameter int unsigned NUM_KEY          = 2,
  parameter int unsigned KEY_PULSE_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trig,
  input  logic [NUM_KEY-1:0] trig_keys,
  output logic [NUM_KEY-1:0] pulse_mask
);

  localparam int unsigned CNT_W = clog2(KEY_PULSE_CYCLES + 1);

  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_KEY-1:0] mask_q;

  // Counter holds the remaining high cycles; the mask drops as it leaves 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else if (trig && (trig_keys != '0)) begin
      mask_q <= mask_q | trig_keys;
      cnt_q  <= CNT_W'(KEY_PULSE_CYCLES);
    end else if (cnt_q == CNT_W'(1)) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign pulse_mask = mask_q;

endmodule

// File: rtl/virtual_pin_bridge.sv
// Host-visible bridge between a JTAG-to-Avalon master and the user design:
// mirrors LEDR/HEX, drives SW/KEY, commits parameter words atomically.
module virtual_pin_bridge
  import virtual_pin_pkg::*;
#(
  parameter int unsigned NUM_SW           = 10,
  parameter int unsigned NUM_KEY          = 2,
  parameter int unsigned NUM_PARAMS       = 3,
  parameter int unsigned PARAM_W          = 32,
  parameter int unsigned RESET_HOLD       = 255,
  parameter int unsigned KEY_PULSE_CYCLES = 50000
) (
  input  logic                          CYCLONEV_CLK_50,
  input  logic                          reset,
  virtual_pin_bridge_if.slave           avs,
  input  logic [LEDR_W-1:0]             LEDR,
  input  logic [HEX_W-1:0]              HEX0,
  input  logic [HEX_W-1:0]              HEX1,
  input  logic [HEX_W-1:0]              HEX2,
  input  logic [HEX_W-1:0]              HEX3,
  input  logic [HEX_W-1:0]              HEX4,
  input  logic [HEX_W-1:0]              HEX5,
  output logic [NUM_SW-1:0]             SW,
  output logic [NUM_KEY-1:0]            KEY,
  output logic [NUM_PARAMS*PARAM_W-1:0] param,
  output logic                          sys_reset_n
);

  localparam int unsigned SWK_W     = NUM_SW + NUM_KEY;
  localparam int unsigned PRM_TOT_W = NUM_PARAMS * PARAM_W;
  localparam int unsigned HOLD_W    = clog2(RESET_HOLD + 1);

  logic [HOLD_W-1:0]     hold_cnt_q;
  logic [HOLD_W-1:0]     hold_cnt_nxt;
  logic                  hold_done_q;
  user_pins_t            pins_in;
  user_pins_t            pins_cur_q;
  user_pins_t            pins_prev_q;
  logic                  chg_q;
  logic [SWK_W-1:0]      sw_key_q;
  logic [PRM_TOT_W-1:0]  shadow_q;
  logic [PRM_TOT_W-1:0]  param_q;
  logic                  pend;
  logic [NUM_KEY-1:0]    pulse_mask;
  logic [AVS_DATA_W-1:0] rd_data;
  logic [AVS_DATA_W-1:0] readdata_q;
  logic                  readdatavalid_q;
  logic                  wr_sw_key;
  logic                  wr_key_pulse;
  logic                  wr_status_clr;
  logic                  wr_commit;
  logic [NUM_PARAMS-1:0] wr_param;

  assign pins_in = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, LEDR};

  // Start-up hold: counts up after reset and parks at RESET_HOLD.
  always_comb begin
    hold_cnt_nxt = hold_cnt_q;
    if (hold_cnt_q != HOLD_W'(RESET_HOLD)) hold_cnt_nxt = hold_cnt_q + HOLD_W'(1);
  end

  always_ff @(posedge CYCLONEV_CLK_50) begin
    if (reset) begin
      hold_cnt_q  <= '0;
      hold_done_q <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_nxt;
      hold_done_q <= (hold_cnt_nxt == HOLD_W'(RESET_HOLD));
    end
  end

  // Write decode.
  always_comb begin
    wr_sw_key     = avs.avs_write && (avs.avs_address == ADDR_SW_KEY);
    wr_key_pulse  = avs.avs_write && (avs.avs_address == ADDR_KEY_PULSE);
    wr_status_clr = avs.avs_write && (avs.avs_address == ADDR_STATUS)
                    && avs.avs_writedata[STAT_CHG];
    wr_commit     = avs.avs_write && (avs.avs_address == ADDR_CTRL)
                    && avs.avs_writedata[0];
    for (int i = 0; i < NUM_PARAMS; i++) begin
      wr_param[i] = avs.avs_write
                    && (avs.avs_address == ADDR_PARAM_BASE + AVS_ADDR_W'(i));
    end
  end

  assign pend = (shadow_q != param_q);

  // Register file; a pending change sample beats a same-cycle clear of chg.
  always_ff @(posedge CYCLONEV_CLK_50) begin
    if (reset) begin
      pins_cur_q      <= '0;
      pins_prev_q     <= '0;
      chg_q           <= 1'b0;
      sw_key_q        <= '0;
      shadow_q        <= '0;
      param_q         <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      pins_cur_q      <= pins_in;
      pins_prev_q     <= pins_cur_q;
      chg_q           <= (pins_cur_q != pins_prev_q) || (chg_q && !wr_status_clr);
      if (wr_sw_key) sw_key_q <= avs.avs_writedata[SWK_W-1:0];
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (wr_param[i]) shadow_q[i*PARAM_W +: PARAM_W] <= avs.avs_writedata[PARAM_W-1:0];
      end
      if (wr_commit) param_q <= shadow_q;
      readdatavalid_q <= avs.avs_read;
      readdata_q      <= avs.avs_read ? rd_data : '0;
    end
  end

  // Read mux sees pre-write state, so a same-cycle write is not reflected.
  always_comb begin
    rd_data = '0;
    case (avs.avs_address)
      ADDR_ID:     rd_data = ID_VALUE;
      ADDR_IN_LO:  rd_data = {pins_cur_q.hex1, pins_cur_q.hex0, 6'b0, pins_cur_q.ledr};
      ADDR_IN_HI:  rd_data = {pins_cur_q.hex5, pins_cur_q.hex4,
                              pins_cur_q.hex3, pins_cur_q.hex2};
      ADDR_SW_KEY: rd_data = AVS_DATA_W'(sw_key_q);
      ADDR_STATUS: begin
        rd_data[STAT_CHG]  = chg_q;
        rd_data[STAT_PEND] = pend;
        rd_data[STAT_HOLD] = hold_done_q;
      end
      default: begin
        for (int i = 0; i < NUM_PARAMS; i++) begin
          if (avs.avs_address == ADDR_PARAM_BASE + AVS_ADDR_W'(i)) begin
            rd_data = AVS_DATA_W'(shadow_q[i*PARAM_W +: PARAM_W]);
          end
        end
      end
    endcase
  end

  vpb_pulse_timer #(
    .NUM_KEY          (NUM_KEY),
    .KEY_PULSE_CYCLES (KEY_PULSE_CYCLES)
  ) u_pulse_timer (
    .clk        (CYCLONEV_CLK_50),
    .reset      (reset),
    .trig       (wr_key_pulse),
    .trig_keys  (avs.avs_writedata[NUM_KEY-1:0]),
    .pulse_mask (pulse_mask)
  );

  assign SW                    = sw_key_q[NUM_SW-1:0];
  assign KEY                   = sw_key_q[SWK_W-1:NUM_SW] | pulse_mask;
  assign param                 = param_q;
  assign sys_reset_n           = hold_done_q;
  assign avs.avs_readdata      = readdata_q;
  assign avs.avs_readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_virtual_pin_bridge.sv
// Scoreboard bench for virtual_pin_bridge with a cycle-level reference model.
// Reads queue their expected data; a monitor pops on readdatavalid.
module tb_virtual_pin_bridge;

  localparam int unsigned NUM_SW           = 10;
  localparam int unsigned NUM_KEY          = 2;
  localparam int unsigned NUM_PARAMS       = 3;
  localparam int unsigned PARAM_W          = 32;
  localparam int unsigned RESET_HOLD       = 255;
  localparam int unsigned KEY_PULSE_CYCLES = 4;

  logic                          CYCLONEV_CLK_50 = 1'b0;
  logic                          reset;
  logic [9:0]                    LEDR;
  logic [7:0]                    HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [NUM_SW-1:0]             SW;
  logic [NUM_KEY-1:0]            KEY;
  logic [NUM_PARAMS*PARAM_W-1:0] param;
  logic                          sys_reset_n;

  virtual_pin_bridge_if bus();

  virtual_pin_bridge #(
    .NUM_SW           (NUM_SW),
    .NUM_KEY          (NUM_KEY),
    .NUM_PARAMS       (NUM_PARAMS),
    .PARAM_W          (PARAM_W),
    .RESET_HOLD       (RESET_HOLD),
    .KEY_PULSE_CYCLES (KEY_PULSE_CYCLES)
  ) dut (
    .CYCLONEV_CLK_50 (CYCLONEV_CLK_50),
    .reset           (reset),
    .avs             (bus),
    .LEDR            (LEDR),
    .HEX0            (HEX0),
    .HEX1            (HEX1),
    .HEX2            (HEX2),
    .HEX3            (HEX3),
    .HEX4            (HEX4),
    .HEX5            (HEX5),
    .SW              (SW),
    .KEY             (KEY),
    .param           (param),
    .sys_reset_n     (sys_reset_n)
  );

  always #10 CYCLONEV_CLK_50 = ~CYCLONEV_CLK_50;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] exp_q[$];
  bit          exp_rdv;

  // Reference model: state as seen after the most recent clock edge.
  int          m_edge;
  int unsigned m_since_rel;
  logic [31:0] m_swkey;
  int          m_key_end[NUM_KEY];
  logic [31:0] m_shadow[NUM_PARAMS];
  logic [31:0] m_param[NUM_PARAMS];
  bit          m_chg;
  logic [9:0]  m_ledr_cur, m_ledr_prev;
  logic [7:0]  m_hex_cur[6];
  logic [7:0]  m_hex_prev[6];

  logic [9:0]  ledr_v;
  logic [7:0]  hex_v[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    bit pend;
    v = '0;
    pend = 0;
    for (int i = 0; i < NUM_PARAMS; i++) if (m_shadow[i] != m_param[i]) pend = 1;
    case (a)
      5'h00: v = 32'h5650_0002;
      5'h01: v = {m_hex_cur[1], m_hex_cur[0], 6'b0, m_ledr_cur};
      5'h02: v = {m_hex_cur[5], m_hex_cur[4], m_hex_cur[3], m_hex_cur[2]};
      5'h03: v = m_swkey;
      5'h05: v = {29'b0, m_since_rel >= RESET_HOLD, pend, m_chg};
      default: begin
        for (int i = 0; i < NUM_PARAMS; i++) if (a == 5'(16 + i)) v = m_shadow[i];
      end
    endcase
    return v;
  endfunction

  task automatic model_step(input bit rst, input bit wr, input logic [4:0] a, input logic [31:0] wd);
    bit changed;
    m_edge++;
    if (rst) begin
      m_since_rel = 0;
      m_swkey     = '0;
      m_chg       = 0;
      m_ledr_cur  = '0;
      m_ledr_prev = '0;
      for (int k = 0; k < NUM_KEY; k++) m_key_end[k] = 0;
      for (int i = 0; i < 6; i++) begin
        m_hex_cur[i]  = '0;
        m_hex_prev[i] = '0;
      end
      for (int i = 0; i < NUM_PARAMS; i++) begin
        m_shadow[i] = '0;
        m_param[i]  = '0;
      end
    end else begin
      changed = (m_ledr_cur != m_ledr_prev);
      for (int i = 0; i < 6; i++) if (m_hex_cur[i] != m_hex_prev[i]) changed = 1;
      if (m_since_rel < 100000) m_since_rel++;
      m_chg = changed || (m_chg && !(wr && a == 5'h05 && wd[0]));
      m_ledr_prev = m_ledr_cur;
      m_ledr_cur  = ledr_v;
      for (int i = 0; i < 6; i++) begin
        m_hex_prev[i] = m_hex_cur[i];
        m_hex_cur[i]  = hex_v[i];
      end
      if (wr) begin
        if (a == 5'h03) m_swkey = wd & 32'h0000_0FFF;
        if (a == 5'h04 && wd[NUM_KEY-1:0] != '0) begin
          for (int k = 0; k < NUM_KEY; k++) begin
            if (wd[k] || m_key_end[k] >= m_edge) m_key_end[k] = m_edge + int'(KEY_PULSE_CYCLES);
          end
        end
        if (a == 5'h06 && wd[0]) for (int i = 0; i < NUM_PARAMS; i++) m_param[i] = m_shadow[i];
        for (int i = 0; i < NUM_PARAMS; i++) if (a == 5'(16 + i)) m_shadow[i] = wd;
      end
    end
  endtask

  task automatic check_outputs();
    logic [NUM_KEY-1:0] ek;
    chk("SW", 32'(SW), m_swkey & 32'h0000_03FF);
    for (int k = 0; k < NUM_KEY; k++) ek[k] = m_swkey[NUM_SW + k] | (m_edge < m_key_end[k]);
    chk("KEY", 32'(KEY), 32'(ek));
    for (int i = 0; i < NUM_PARAMS; i++) chk($sformatf("param%0d", i), param[i*32 +: 32], m_param[i]);
    chk("sys_reset_n", 32'(sys_reset_n), 32'(m_since_rel >= RESET_HOLD));
    chk("readdatavalid", 32'(bus.avs_readdatavalid), 32'(exp_rdv));
  endtask

  task automatic cycle(input bit rst, input bit rd, input bit wr, input logic [4:0] a, input logic [31:0] wd);
    reset             = rst;
    bus.avs_read      = rd;
    bus.avs_write     = wr;
    bus.avs_address   = a;
    bus.avs_writedata = wd;
    LEDR = ledr_v;
    HEX0 = hex_v[0]; HEX1 = hex_v[1]; HEX2 = hex_v[2];
    HEX3 = hex_v[3]; HEX4 = hex_v[4]; HEX5 = hex_v[5];
    if (rd && !rst) exp_q.push_back(model_read(a));
    exp_rdv = rd && !rst;
    model_step(rst, wr, a, wd);
    @(negedge CYCLONEV_CLK_50);
    check_outputs();
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    cycle(0, 0, 1, a, d);
  endtask

  task automatic rd_reg(input logic [4:0] a);
    cycle(0, 1, 0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 5'h00, 32'h0);
  endtask

  task automatic random_cycle();
    bit rd, wr;
    logic [4:0] a;
    int unsigned sel;
    rd  = ($urandom % 3) == 0;
    wr  = ($urandom % 3) == 0;
    sel = $urandom % 10;
    if (sel < 7)      a = 5'(sel);
    else if (sel < 9) a = 5'(16 + ($urandom % NUM_PARAMS));
    else              a = 5'($urandom % 32);
    if (($urandom % 4) == 0) begin
      ledr_v = 10'($urandom);
      for (int i = 0; i < 6; i++) hex_v[i] = 8'($urandom);
    end
    cycle(0, rd, wr, a, $urandom);
  endtask

  // Monitor: every valid read beat must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge CYCLONEV_CLK_50);
      if (bus.avs_readdatavalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL rdata: got unexpected readdatavalid, required none at %0t", $time);
        end else begin
          chk("rdata", bus.avs_readdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    m_edge = 0;
    m_since_rel = 0;
    m_swkey = '0;
    m_chg = 0;
    m_ledr_cur = '0;
    m_ledr_prev = '0;
    exp_rdv = 0;
    ledr_v = '0;
    for (int i = 0; i < 6; i++) begin
      hex_v[i] = '0;
      m_hex_cur[i] = '0;
      m_hex_prev[i] = '0;
    end
    for (int k = 0; k < NUM_KEY; k++) m_key_end[k] = 0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      m_shadow[i] = '0;
      m_param[i] = '0;
    end

    repeat (3) cycle(1, 0, 0, 5'h00, 32'h0);
    repeat (100) random_cycle();
    repeat (2) cycle(1, 0, 0, 5'h00, 32'h0);

    rd_reg(5'h00);
    wr_reg(5'h00, 32'hFFFF_FFFF);
    rd_reg(5'h00);
    wr_reg(5'h10, 32'h1111);
    wr_reg(5'h11, 32'h2222);
    wr_reg(5'h12, 32'h3333);
    rd_reg(5'h05);
    wr_reg(5'h06, 32'h1);
    rd_reg(5'h05);
    rd_reg(5'h11);
    wr_reg(5'h04, 32'h1);
    idle(2);
    wr_reg(5'h04, 32'h2);
    idle(6);
    wr_reg(5'h04, 32'h0);
    wr_reg(5'h03, 32'h2AA);
    rd_reg(5'h03);
    rd_reg(5'h1F);
    ledr_v = 10'h155;
    hex_v[0] = 8'hC0;
    idle(3);
    rd_reg(5'h01);
    rd_reg(5'h05);
    wr_reg(5'h05, 32'h1);
    rd_reg(5'h05);
    ledr_v = 10'h0AA;
    idle(1);
    wr_reg(5'h05, 32'h1);
    rd_reg(5'h05);
    cycle(0, 1, 1, 5'h10, 32'hDEAD_BEEF);
    rd_reg(5'h10);

    repeat (1500) random_cycle();
    idle(250);
    rd_reg(5'h05);
    idle(3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
